// File: rtl/branch_equator.sv
// ID-stage branch resolution: signed compare of A/B under BranchSelect, flush request and its
// one-cycle-delayed copy. Define BRANCH_EQ_STATS_EN to add the saturating TakenCount counter.
module branch_equator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       BranchSelect,
  input  logic             Branch,
  input  logic             Jump,
  output logic             BranchingSoFlush,
`ifdef BRANCH_EQ_STATS_EN
  output logic             FlushDelayed,
  output logic [15:0]      TakenCount
`else
  output logic             FlushDelayed
`endif
);

  localparam logic [2:0] SEL_BLT = 3'b000;
  localparam logic [2:0] SEL_BGT = 3'b001;
  localparam logic [2:0] SEL_BEQ = 3'b010;
  localparam logic [2:0] SEL_BNE = 3'b011;
  localparam logic [2:0] SEL_BLE = 3'b100;
  localparam logic [2:0] SEL_BGE = 3'b101;

  logic signed [WIDTH-1:0] signedA;
  logic signed [WIDTH-1:0] signedB;
  logic                    lessThan;
  logic                    equal;
  logic                    cond;

  assign signedA  = A;
  assign signedB  = B;
  assign lessThan = signedA < signedB;
  assign equal    = (A == B);

  always_comb begin
    cond = 1'b0;
    case (BranchSelect)
      SEL_BLT: cond = lessThan;
      SEL_BGT: cond = !lessThan && !equal;
      SEL_BEQ: cond = equal;
      SEL_BNE: cond = !equal;
      SEL_BLE: cond = lessThan || equal;
      SEL_BGE: cond = !lessThan;
      default: cond = 1'b0;
    endcase
  end

  // Jump short-circuits the compare so unknown operands cannot mask a jump.
  assign BranchingSoFlush = Jump ? 1'b1 : (Branch & cond);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FlushDelayed <= 1'b0;
    end else begin
      FlushDelayed <= BranchingSoFlush;
    end
  end

`ifdef BRANCH_EQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TakenCount <= 16'h0000;
    end else if (BranchingSoFlush && (TakenCount != 16'hFFFF)) begin
      TakenCount <= TakenCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_equator.sv
// Self-checking bench for branch_equator: directed test-plan vectors, randomized compare and
// registered-path checks against an arithmetic reference model, reset and optional counter checks.
module tb_branch_equator;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   branch_select;
  logic         branch;
  logic         jump;
  logic         branching_so_flush;
  logic         flush_delayed;
`ifdef BRANCH_EQ_STATS_EN
  logic [15:0]  taken_count;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic exp_q[$];

  branch_equator #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .A                (a),
    .B                (b),
    .BranchSelect     (branch_select),
    .Branch           (branch),
    .Jump             (jump),
    .BranchingSoFlush (branching_so_flush),
`ifdef BRANCH_EQ_STATS_EN
    .FlushDelayed     (flush_delayed),
    .TakenCount       (taken_count)
`else
    .FlushDelayed     (flush_delayed)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: operands as plain integers in two's complement
  function automatic int to_int(input logic [W-1:0] v);
    int r;
    r = int'(v);
    if (v >= (1 << (W - 1))) r = r - (1 << W);
    return r;
  endfunction

  function automatic logic model_flush(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic [2:0] sel, input logic br, input logic jp);
    int sa;
    int sb;
    if (jp) return 1'b1;
    if (!br) return 1'b0;
    sa = to_int(ma);
    sb = to_int(mb);
    case (sel)
      3'd0: return sa <  sb;
      3'd1: return sa >  sb;
      3'd2: return sa == sb;
      3'd3: return sa != sb;
      3'd4: return sa <= sb;
      3'd5: return sa >= sb;
      default: return 1'b0;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic [2:0] sel,
                       input logic br, input logic jp);
    a = da;
    b = db;
    branch_select = sel;
    branch = br;
    jump = jp;
  endtask

  task automatic drive_random();
    drive(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(16'd5, 16'd5, 3'b010, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_cnt++;
    if (flush_delayed !== 1'b0) $display("FAIL reset_fd actual=%b required=0", flush_delayed);
    else pass_cnt++;
`ifdef BRANCH_EQ_STATS_EN
    check_cnt++;
    if (taken_count !== 16'h0) $display("FAIL reset_count actual=%h required=0000", taken_count);
    else pass_cnt++;
`endif
    // release reset with a taken BEQ held for exactly one cycle
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_cnt++;
    if (flush_delayed !== 1'b0) $display("FAIL pre_edge_fd actual=%b required=0", flush_delayed);
    else pass_cnt++;
    @(posedge clk);
    #1;
    check_cnt++;
    if (flush_delayed !== 1'b1) $display("FAIL first_edge_fd actual=%b required=1", flush_delayed);
    else pass_cnt++;
    @(negedge clk);
    drive(16'd1, 16'd0, 3'b010, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_cnt++;
    if (flush_delayed !== 1'b0) $display("FAIL second_edge_fd actual=%b required=0", flush_delayed);
    else pass_cnt++;
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [2:0]   sel;
    logic         br;
    logic         jp;
    logic         exp;
  } vec_t;

  task automatic test_directed();
    vec_t v[20];
    v[0]  = '{16'd1, 16'd0, 3'b000, 1'b1, 1'b0, 1'b0};
    v[1]  = '{16'd1, 16'd1, 3'b000, 1'b1, 1'b0, 1'b0};
    v[2]  = '{16'd0, 16'd1, 3'b000, 1'b1, 1'b0, 1'b1};
    v[3]  = '{16'hFFFF, 16'd0, 3'b000, 1'b1, 1'b0, 1'b1};
    v[4]  = '{16'd1, 16'd0, 3'b001, 1'b1, 1'b0, 1'b1};
    v[5]  = '{16'd1, 16'd1, 3'b001, 1'b1, 1'b0, 1'b0};
    v[6]  = '{16'd0, 16'd1, 3'b001, 1'b1, 1'b0, 1'b0};
    v[7]  = '{16'd1, 16'd0, 3'b010, 1'b1, 1'b0, 1'b0};
    v[8]  = '{16'd1, 16'd1, 3'b010, 1'b1, 1'b0, 1'b1};
    v[9]  = '{16'd0, 16'd1, 3'b010, 1'b1, 1'b0, 1'b0};
    v[10] = '{16'd1, 16'd0, 3'b000, 1'b1, 1'b1, 1'b1};
    v[11] = '{16'd1, 16'd1, 3'b001, 1'b1, 1'b1, 1'b1};
    v[12] = '{16'd0, 16'd1, 3'b011, 1'b1, 1'b1, 1'b1};
    v[13] = '{16'd3, 16'd9, 3'b111, 1'b0, 1'b1, 1'b1};
    v[14] = '{16'd5, 16'd5, 3'b010, 1'b0, 1'b0, 1'b0};
    v[15] = '{16'd5, 16'd5, 3'b110, 1'b1, 1'b0, 1'b0};
    v[16] = '{16'h8000, 16'h7FFF, 3'b001, 1'b1, 1'b0, 1'b0};
    v[17] = '{16'h8000, 16'h7FFF, 3'b100, 1'b1, 1'b0, 1'b1};
    v[18] = '{16'h7FFF, 16'h7FFF, 3'b101, 1'b1, 1'b0, 1'b1};
    v[19] = '{16'h0005, 16'h0005, 3'b011, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(v[i].va, v[i].vb, v[i].sel, v[i].br, v[i].jp);
      #1;
      check_cnt++;
      if (branching_so_flush !== v[i].exp)
        $display("FAIL directed[%0d] a=%h b=%h sel=%b br=%b jp=%b actual=%b required=%b",
                 i, v[i].va, v[i].vb, v[i].sel, v[i].br, v[i].jp, branching_so_flush, v[i].exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_jump_unknown();
    @(negedge clk);
    drive('x, 'x, 3'b000, 1'b1, 1'b1);
    #1;
    check_cnt++;
    if (branching_so_flush !== 1'b1)
      $display("FAIL jump_unknown actual=%b required=1", branching_so_flush);
    else pass_cnt++;
  endtask

  task automatic test_random_comb();
    logic e;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive_random();
      // bias towards equal or adjacent operands so boundaries get hit
      if ($urandom_range(0, 3) == 0) b = a + W'($urandom_range(0, 2)) - W'(1);
      #1;
      e = model_flush(a, b, branch_select, branch, jump);
      check_cnt++;
      if (branching_so_flush !== e)
        $display("FAIL random_comb a=%h b=%h sel=%b br=%b jp=%b actual=%b required=%b",
                 a, b, branch_select, branch, jump, branching_so_flush, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive_random();
      exp_q.push_back(model_flush(a, b, branch_select, branch, jump));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_cnt++;
      if (flush_delayed !== e)
        $display("FAIL back_to_back[%0d] actual=%b required=%b", i, flush_delayed, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(16'd0, 16'd0, 3'b000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_cnt++;
    if (flush_delayed !== 1'b1) $display("FAIL mid_pre actual=%b required=1", flush_delayed);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (flush_delayed !== 1'b0) $display("FAIL mid_async_clear actual=%b required=0", flush_delayed);
    else pass_cnt++;
    check_cnt++;
    if (branching_so_flush !== 1'b1)
      $display("FAIL mid_comb_follows actual=%b required=1", branching_so_flush);
    else pass_cnt++;
    @(posedge clk);
    #1;
    check_cnt++;
    if (flush_delayed !== 1'b0) $display("FAIL mid_held actual=%b required=0", flush_delayed);
    else pass_cnt++;
    @(negedge clk);
    drive(16'd0, 16'd0, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_cnt++;
    if (flush_delayed !== 1'b0) $display("FAIL mid_release actual=%b required=0", flush_delayed);
    else pass_cnt++;
  endtask

`ifdef BRANCH_EQ_STATS_EN
  task automatic test_stats();
    int exp_count;
    @(negedge clk);
    drive(16'd0, 16'd0, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (taken_count !== 16'h0) $display("FAIL stats_clear actual=%h required=0000", taken_count);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(16'hFFFE, 16'd2, 3'b000, 1'b1, 1'b0);
      @(posedge clk);
      exp_count++;
    end
    @(negedge clk);
    drive(16'd2, 16'd2, 3'b011, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_cnt++;
    if (taken_count !== 16'(exp_count))
      $display("FAIL stats_three actual=%h required=%h", taken_count, 16'(exp_count));
    else pass_cnt++;
    @(negedge clk);
    drive(16'd0, 16'd0, 3'b111, 1'b0, 1'b1);
    while (exp_count < 65535) begin
      @(posedge clk);
      exp_count++;
    end
    #1;
    check_cnt++;
    if (taken_count !== 16'hFFFF)
      $display("FAIL stats_reach_max actual=%h required=ffff", taken_count);
    else pass_cnt++;
    repeat (5) @(posedge clk);
    #1;
    check_cnt++;
    if (taken_count !== 16'hFFFF)
      $display("FAIL stats_saturate actual=%h required=ffff", taken_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_jump_unknown();
    test_random_comb();
    test_back_to_back();
    test_reset_mid();
`ifdef BRANCH_EQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
